// File: rtl/ad9361_spi_multibyte_master_if.sv
// Request/response bus between the config sequencer (master) and the AD9361 SPI master (slave).
interface ad9361_spi_multibyte_master_if #(
  parameter int unsigned MAX_BYTES = 4
);
  logic                   i_Start;
  logic                   i_Wr_nRd;
  logic [9:0]             i_Addr;
  logic [2:0]             i_Nbytes_m1;
  logic [8*MAX_BYTES-1:0] i_Wr_Data;
  logic                   o_Ready;
  logic                   o_Done;
  logic [8*MAX_BYTES-1:0] o_Rd_Data;

  modport master (
    output i_Start, i_Wr_nRd, i_Addr, i_Nbytes_m1, i_Wr_Data,
    input  o_Ready, o_Done, o_Rd_Data
  );

  modport slave (
    input  i_Start, i_Wr_nRd, i_Addr, i_Nbytes_m1, i_Wr_Data,
    output o_Ready, o_Done, o_Rd_Data
  );
endinterface

// File: rtl/ad9361_spi_multibyte_master.sv
// AD9361 SPI master: 16-bit instruction plus 1..MAX_BYTES data bytes in one CS_n window.
// Define AD9361_SPI_3WIRE_EN for 3-wire SDIO operation (adds o_SPI_SDIO_OE).
module ad9361_spi_multibyte_master #(
  parameter int unsigned CLKS_PER_HALF_BIT = 2,
  parameter int unsigned MAX_BYTES         = 4,
  parameter int unsigned CS_GAP            = 4
) (
  input  logic                         i_Clk,
  input  logic                         i_Rst_L,
  ad9361_spi_multibyte_master_if.slave bus,
  output logic                         o_SPI_Clk,
  output logic                         o_SPI_CS_n,
  output logic                         o_SPI_MOSI,
`ifdef AD9361_SPI_3WIRE_EN
  output logic                         o_SPI_SDIO_OE,
`endif
  input  logic                         i_SPI_MISO
);
  localparam int unsigned H       = CLKS_PER_HALF_BIT;
  localparam int unsigned DATA_W  = 8 * MAX_BYTES;
  localparam int unsigned FRAME_W = 16 + DATA_W;
  localparam int unsigned BIT_W   = $clog2(FRAME_W);
  localparam int unsigned IDX_W   = $clog2(DATA_W);
  localparam int unsigned CNT_MAX = (2 * H - 1 > CS_GAP) ? 2 * H - 1 : CS_GAP;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [BIT_W-1:0]     last_q, last_d;
  logic                 wr_q, wr_d;
  logic [FRAME_W-1:0]   shreg_q, shreg_d;
  logic [DATA_W-1:0]    rx_q, rx_d;
  logic                 sclk_q, sclk_d;
  logic                 cs_n_q, cs_n_d;
  logic                 mosi_q, mosi_d;
  logic                 ready_q, ready_d;
  logic                 done_q, done_d;
  logic [DATA_W-1:0]    rd_q, rd_d;

  logic [2:0]           n_clamp;
  logic [15:0]          header;
  logic [DATA_W-1:0]    payload;
  logic [FRAME_W-1:0]   frame;
  logic [BIT_W-1:0]     data_bit;
  logic [IDX_W-1:0]     rx_pos;

  // Frame image built from the live request; only captured on acceptance
  always_comb begin
    n_clamp = (bus.i_Nbytes_m1 > 3'(MAX_BYTES - 1)) ? 3'(MAX_BYTES - 1) : bus.i_Nbytes_m1;
    header  = {bus.i_Wr_nRd, n_clamp, 2'b00, bus.i_Addr};
    payload = '0;
    for (int k = 0; k < int'(MAX_BYTES); k++) begin
      if (bus.i_Wr_nRd && (k <= int'(n_clamp))) begin
        payload[DATA_W - 8 - 8 * k +: 8] = bus.i_Wr_Data[8 * k +: 8];
      end
    end
    frame = {header, payload};
  end

  // Received data bit n lands in byte n/8, MSB first within the byte
  always_comb begin
    data_bit = bit_q - BIT_W'(16);
    rx_pos   = IDX_W'(data_bit ^ BIT_W'(7));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    last_d  = last_q;
    wr_d    = wr_q;
    shreg_d = shreg_q;
    rx_d    = rx_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    mosi_d  = mosi_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    rd_d    = rd_q;

    case (state_q)
      IDLE: begin
        if (bus.i_Start) begin
          state_d = SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
          last_d  = BIT_W'(8 * int'(n_clamp) + 23);
          wr_d    = bus.i_Wr_nRd;
          mosi_d  = frame[FRAME_W-1];
          shreg_d = {frame[FRAME_W-2:0], 1'b0};
          rx_d    = '0;
          sclk_d  = 1'b0;
          cs_n_d  = 1'b0;
          ready_d = 1'b0;
        end
      end

      SHIFT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(H - 1)) begin
          sclk_d = 1'b1;
          if (!wr_q && (bit_q >= BIT_W'(16))) begin
            rx_d[rx_pos] = i_SPI_MISO;
          end
        end else if (cnt_q == CNT_W'(2 * H - 1)) begin
          sclk_d = 1'b0;
          cnt_d  = '0;
          if (bit_q == last_q) begin
            state_d = HOLD;
            mosi_d  = 1'b0;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            mosi_d  = shreg_q[FRAME_W-1];
            shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
          end
        end
      end

      HOLD: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(H - 1)) begin
          state_d = GAP;
          cnt_d   = '0;
          cs_n_d  = 1'b1;
          done_d  = 1'b1;
          if (!wr_q) begin
            rd_d = rx_q;
          end
        end
      end

      GAP: begin
        // Done cycle plus CS_GAP idle cycles before the next request
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(CS_GAP)) begin
          state_d = IDLE;
          cnt_d   = '0;
          ready_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      last_q  <= '0;
      wr_q    <= 1'b0;
      shreg_q <= '0;
      rx_q    <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      shreg_q <= shreg_d;
      rx_q    <= rx_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      mosi_q  <= mosi_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      rd_q    <= rd_d;
    end
  end

`ifdef AD9361_SPI_3WIRE_EN
  logic oe_q;

  // Drive SDIO through header and write data; release after header bit 0 on reads
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      oe_q <= 1'b0;
    end else if (state_q == IDLE && bus.i_Start) begin
      oe_q <= 1'b1;
    end else if (state_q == SHIFT && !wr_q && bit_q == BIT_W'(15) && cnt_q == CNT_W'(2 * H - 1)) begin
      oe_q <= 1'b0;
    end else if (state_q == HOLD && cnt_q == CNT_W'(H - 1)) begin
      oe_q <= 1'b0;
    end
  end

  assign o_SPI_SDIO_OE = oe_q;
`endif

  assign o_SPI_Clk     = sclk_q;
  assign o_SPI_CS_n    = cs_n_q;
  assign o_SPI_MOSI    = mosi_q;
  assign bus.o_Ready   = ready_q;
  assign bus.o_Done    = done_q;
  assign bus.o_Rd_Data = rd_q;
endmodule

// File: tb/tb_ad9361_spi_multibyte_master.sv
// Bench for ad9361_spi_multibyte_master: directed vectors, queued expectations, SPI slave model.
`timescale 1ns/1ps
module tb_ad9361_spi_multibyte_master;
  localparam int unsigned H   = 2;
  localparam int unsigned MB  = 4;
  localparam int unsigned CSG = 4;

  typedef struct {
    logic        wr;
    logic [9:0]  addr;
    logic [2:0]  nm1;
    logic [31:0] wdata;
    logic [31:0] sdata;   // slave bytes, byte k in [8k+7:8k]
    logic [15:0] hdr;
    logic [31:0] rd;
    int          bits;
  } vec_t;

  typedef struct {
    logic [79:0] bits;
    int          nbits;
    bit          abort;
  } frame_t;

  logic clk = 1'b0;
  logic rst_n;
  logic sclk, cs_n, mosi, miso;
`ifdef AD9361_SPI_3WIRE_EN
  logic sdio_oe;
`endif

  ad9361_spi_multibyte_master_if #(.MAX_BYTES(MB)) bus ();

  ad9361_spi_multibyte_master #(
    .CLKS_PER_HALF_BIT(H),
    .MAX_BYTES        (MB),
    .CS_GAP           (CSG)
  ) dut (
    .i_Clk        (clk),
    .i_Rst_L      (rst_n),
    .bus          (bus),
    .o_SPI_Clk    (sclk),
    .o_SPI_CS_n   (cs_n),
    .o_SPI_MOSI   (mosi),
`ifdef AD9361_SPI_3WIRE_EN
    .o_SPI_SDIO_OE(sdio_oe),
`endif
    .i_SPI_MISO   (miso)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] done_q[$];
  int          low_q[$];
  frame_t      frame_q[$];
  logic [31:0] last_rd = '0;

  logic [79:0] slave_frame = '1;
  int          sfalls = 0;
  logic [79:0] cap = '0;
  int          rises = 0;
  bit          in_frame = 1'b0;
  frame_t      ef;
  int          low_cnt = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s at time %0t", name, $time);
  endtask

  // Slave: presents the next MISO bit at CS_n fall and on each SCLK fall
  always @(negedge sclk or posedge cs_n) begin
    if (cs_n === 1'b1) sfalls = 0;
    else sfalls++;
  end
  assign miso = (sfalls < 80) ? slave_frame[7'(79 - sfalls)] : 1'b0;

  // MOSI capture per SCLK rise; whole frame compared when CS_n returns high
  always @(posedge sclk or negedge cs_n or posedge cs_n) begin
    if (cs_n === 1'b1) begin
      if (in_frame) begin
        in_frame = 1'b0;
        if (frame_q.size() == 0) begin
          note_fail("frame_unexpected");
        end else begin
          ef = frame_q.pop_front();
          if (!ef.abort) begin
            check("sclk_rises", 80'(rises), 80'(ef.nbits));
            check("mosi_frame", cap, ef.bits);
          end
        end
      end
    end else if (sclk === 1'b0) begin
      in_frame = 1'b1;
      cap      = '0;
      rises    = 0;
    end else begin
      cap = {cap[78:0], mosi};
      rises++;
    end
  end

  // Response monitor: o_Done data and o_Ready-low duration
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      low_cnt = 0;
    end else begin
      if (bus.o_Done === 1'b1) begin
        if (done_q.size() == 0) note_fail("done_unexpected");
        else check("rd_data", 80'(bus.o_Rd_Data), 80'(done_q.pop_front()));
      end
      if (bus.o_Ready === 1'b0) begin
        low_cnt++;
      end else if (low_cnt != 0) begin
        if (low_q.size() == 0) note_fail("ready_low_unexpected");
        else check("ready_low_cycles", 80'(low_cnt), 80'(low_q.pop_front()));
        low_cnt = 0;
      end
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.o_Ready === 1'b1) return;
    end
    note_fail("ready_timeout");
  endtask

  task automatic wait_done();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.o_Done === 1'b1) return;
    end
    note_fail("done_timeout");
  endtask

  task automatic issue(input vec_t v, input bit abort);
    logic [79:0] fb;
    int nb;
    wait_ready();
    nb = (v.bits - 16) / 8;
    fb = 80'(v.hdr);
    for (int k = 0; k < nb; k++) begin
      fb = (fb << 8) | (v.wr ? 80'(v.wdata[8 * k +: 8]) : 80'h0);
    end
    slave_frame = {16'hFFFF, v.sdata[7:0], v.sdata[15:8], v.sdata[23:16], v.sdata[31:24], 32'hFFFF_FFFF};
    frame_q.push_back('{fb, v.bits, abort});
    if (!abort) begin
      done_q.push_back(v.wr ? last_rd : v.rd);
      low_q.push_back(2 * H * v.bits + H + 1 + CSG);
      if (!v.wr) last_rd = v.rd;
    end
    bus.i_Wr_nRd    = v.wr;
    bus.i_Addr      = v.addr;
    bus.i_Nbytes_m1 = v.nm1;
    bus.i_Wr_Data   = v.wdata;
    bus.i_Start     = 1'b1;
    @(negedge clk);
    bus.i_Start     = 1'b0;
  endtask

  task automatic pulse_junk_start();
    bus.i_Start     = 1'b1;
    bus.i_Wr_nRd    = 1'b0;
    bus.i_Addr      = 10'h3FF;
    bus.i_Nbytes_m1 = 3'd3;
    bus.i_Wr_Data   = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.i_Start     = 1'b0;
  endtask

  vec_t vecs[6];
  vec_t v_ign;

  initial begin
    vecs[0] = '{1'b1, 10'h3F5, 3'd0, 32'h0000_00A5, 32'h1234_5678, 16'h83F5, 32'h0,         24};
    vecs[1] = '{1'b0, 10'h037, 3'd0, 32'h0,         32'hEEEE_EE5C, 16'h0037, 32'h0000_005C, 24};
    vecs[2] = '{1'b0, 10'h100, 3'd3, 32'h0,         32'h4433_2211, 16'h3100, 32'h4433_2211, 48};
    vecs[3] = '{1'b1, 10'h2AB, 3'd7, 32'hDEAD_BEEF, 32'h0F0F_0F0F, 16'hB2AB, 32'h0,         48};
    vecs[4] = '{1'b0, 10'h3FF, 3'd1, 32'h0,         32'hAAAA_7766, 16'h13FF, 32'h0000_7766, 32};
    vecs[5] = '{1'b1, 10'h155, 3'd2, 32'h00C3_B2A1, 32'h5555_5555, 16'hA155, 32'h0,         40};
    v_ign   = '{1'b1, 10'h0F0, 3'd1, 32'h0000_5AA5, 32'h3C3C_3C3C, 16'h90F0, 32'h0,         32};

    rst_n           = 1'b0;
    bus.i_Start     = 1'b0;
    bus.i_Wr_nRd    = 1'b0;
    bus.i_Addr      = '0;
    bus.i_Nbytes_m1 = '0;
    bus.i_Wr_Data   = '0;
    repeat (3) @(negedge clk);
    check("rst_cs_n",  80'(cs_n), 80'(1));
    check("rst_sclk",  80'(sclk), 80'(0));
    check("rst_mosi",  80'(mosi), 80'(0));
    check("rst_ready", 80'(bus.o_Ready), 80'(1));
    check("rst_done",  80'(bus.o_Done), 80'(0));
    check("rst_rd",    80'(bus.o_Rd_Data), 80'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) issue(vecs[i], 1'b0);

    // Starts while busy or in the gap are dropped; changed inputs must not leak into the frame
    issue(v_ign, 1'b0);
    repeat (20) @(negedge clk);
    pulse_junk_start();
    wait_done();
    repeat (2) @(negedge clk);
    check("gap_ready_low", 80'(bus.o_Ready), 80'(0));
    pulse_junk_start();
    wait_ready();
    repeat (3) @(negedge clk);
    check("idle_cs_n_after_gap",  80'(cs_n), 80'(1));
    check("idle_ready_after_gap", 80'(bus.o_Ready), 80'(1));

    // Reset part way through a read: immediate abort, no completion
    issue(vecs[2], 1'b1);
    for (int i = 0; i < 2000 && rises < 11; i++) @(negedge clk);
    if (rises < 11) note_fail("abort_bit_timeout");
    #2 rst_n = 1'b0;
    #1;
    check("abort_cs_n",  80'(cs_n), 80'(1));
    check("abort_sclk",  80'(sclk), 80'(0));
    check("abort_ready", 80'(bus.o_Ready), 80'(1));
    check("abort_done",  80'(bus.o_Done), 80'(0));
    repeat (3) @(negedge clk);
    rst_n   = 1'b1;
    last_rd = '0;
    check("abort_rd_cleared", 80'(bus.o_Rd_Data), 80'(0));
    issue(vecs[1], 1'b0);
    issue(vecs[3], 1'b0);

    wait_ready();
    repeat (5) @(negedge clk);
    check("done_q_left",  80'(done_q.size()), 80'(0));
    check("low_q_left",   80'(low_q.size()), 80'(0));
    check("frame_q_left", 80'(frame_q.size()), 80'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
